// File: rtl/sum_result_buffer_if.sv
// Stream bundle between the adder result producer, the buffer and its consumer.
//   in_valid/in_data   : adder result, one-cycle pulse, no backpressure
//   out_valid/out_data : FIFO head, first-word fall-through
//   out_ready          : consumer accepts the head this cycle
// master = producer/consumer side, slave = buffer side.
interface sum_result_buffer_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/sum_result_buffer.sv
// Captures every adder result into a small FIFO and replays it on a ready/valid
// stream. Results arriving while full (and not draining) are dropped and flagged
// in a sticky overflow bit. Also keeps a wrapping sum and a saturating count of
// everything delivered downstream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream bundle (slave side)
//   level      : stored entry count, 0..DEPTH
//   overflow   : sticky drop flag, cleared by clr_ovf (drop wins)
//   clr_ovf    : synchronous clear of overflow
//   acc        : sum of popped values modulo 2^ACC_W
//   acc_cnt    : number of pops, saturating at 16'hFFFF
module sum_result_buffer #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sum_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [ACC_W-1:0]       acc,
  output logic [15:0]            acc_cnt
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          full_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic [LW-1:0] level_nxt_c;

  // Handshake decode; a pop frees a slot for a same-edge push when full.
  always_comb begin
    full_c = (level == LW'(DEPTH));
    pop_c  = bus.out_valid & bus.out_ready;
    push_c = bus.in_valid & (~full_c | pop_c);
    drop_c = bus.in_valid & full_c & ~pop_c;
  end

  // Next occupancy.
  always_comb begin
    level_nxt_c = level;
    case ({push_c, pop_c})
      2'b10:   level_nxt_c = level + LW'(1);
      2'b01:   level_nxt_c = level - LW'(1);
      default: level_nxt_c = level;
    endcase
  end

  // Storage needs no reset; contents are only observed behind out_valid.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.in_data;
  end

  // Head read from registered storage only, so no in_data -> out_data path.
  assign bus.out_data = mem[rd_ptr];

  // Pointers, occupancy and registered head-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      level         <= level_nxt_c;
      bus.out_valid <= (level_nxt_c != LW'(0));
    end
  end

  // Sticky drop flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Delivered-data statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (pop_c) begin
      acc <= acc + ACC_W'(bus.out_data);
      if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_sum_result_buffer.sv
// Directed bench for sum_result_buffer: a default instance (ACC_W=32) plus an
// ACC_W=W=16 instance for accumulator wrap, both fed from the same stimulus,
// and a small registered adder model for the end-to-end scenario.
module tb_sum_result_buffer;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        tb_valid, tb_ready, tb_clr, use_adder;
  logic [15:0] tb_data;

  // Registered adder model: y/valid one cycle after start.
  logic        add_start, add_valid;
  logic [15:0] add_a, add_b, add_y;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_valid <= 1'b0;
      add_y     <= '0;
    end else begin
      add_valid <= add_start;
      if (add_start) add_y <= add_a + add_b;
    end
  end

  sum_result_buffer_if #(.W(16)) bus ();
  sum_result_buffer_if #(.W(16)) bus16 ();

  assign bus.in_valid    = use_adder ? add_valid : tb_valid;
  assign bus.in_data     = use_adder ? add_y : tb_data;
  assign bus.out_ready   = tb_ready;
  assign bus16.in_valid  = use_adder ? add_valid : tb_valid;
  assign bus16.in_data   = use_adder ? add_y : tb_data;
  assign bus16.out_ready = tb_ready;

  logic [2:0]  level, level16;
  logic        overflow, overflow16;
  logic [31:0] acc;
  logic [15:0] acc16;
  logic [15:0] acc_cnt, acc_cnt16;

  sum_result_buffer #(.W(16), .DEPTH(4), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .level(level), .overflow(overflow),
    .clr_ovf(tb_clr), .acc(acc), .acc_cnt(acc_cnt)
  );

  sum_result_buffer #(.W(16), .DEPTH(4), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .level(level16), .overflow(overflow16),
    .clr_ovf(tb_clr), .acc(acc16), .acc_cnt(acc_cnt16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tb_valid = 1'b0; tb_data = '0; tb_ready = 1'b0; tb_clr = 1'b0;
    use_adder = 1'b0; add_start = 1'b0; add_a = '0; add_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d exp 0", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    n_checks++; if (acc !== 32'd0) begin n_fail++; $display("FAIL reset_acc: got %h exp 0", acc); end
    n_checks++; if (acc_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_acc_cnt: got %0d exp 0", acc_cnt); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (level !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got level %0d valid %b exp 0 0", level, bus.out_valid); end
  endtask

  task automatic test_pass_through();
    do_reset();
    tb_valid = 1'b1; tb_data = 16'h0123; tb_ready = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pt_no_bypass: got %b exp 0", bus.out_valid); end
    tick();
    tb_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0123) begin n_fail++; $display("FAIL pt_head: got %b/%h exp 1/0123", bus.out_valid, bus.out_data); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL pt_level1: got %0d exp 1", level); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL pt_drained: got valid %b level %0d exp 0 0", bus.out_valid, level); end
    n_checks++; if (acc !== 32'h123 || acc_cnt !== 16'd1) begin n_fail++; $display("FAIL pt_acc: got %h/%0d exp 00000123/1", acc, acc_cnt); end
  endtask

  task automatic test_fill_drop();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tb_valid = 1'b1; tb_data = 16'(i);
      tick();
      n_checks++; if (level !== 3'((i > 4) ? 4 : i)) begin n_fail++; $display("FAIL fd_level_%0d: got %0d exp %0d", i, level, (i > 4) ? 4 : i); end
      n_checks++; if (overflow !== (i == 5)) begin n_fail++; $display("FAIL fd_ovf_%0d: got %b exp %b", i, overflow, i == 5); end
    end
    tb_valid = 1'b0; tb_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(k)) begin n_fail++; $display("FAIL fd_out_%0d: got %b/%0d exp 1/%0d", k, bus.out_valid, bus.out_data, k); end
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL fd_empty: got valid %b level %0d exp 0 0", bus.out_valid, level); end
    n_checks++; if (acc !== 32'd10 || acc_cnt !== 16'd4) begin n_fail++; $display("FAIL fd_acc: got %0d/%0d exp 10/4", acc, acc_cnt); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fd_sticky: got %b exp 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_q [4];
    exp_q = '{16'd20, 16'd30, 16'd40, 16'd50};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tb_valid = 1'b1; tb_data = 16'(10 * i);
      tick();
    end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fpp_full: got %0d exp 4", level); end
    tb_data = 16'd50; tb_ready = 1'b1;
    n_checks++; if (bus.out_data !== 16'd10) begin n_fail++; $display("FAIL fpp_head: got %0d exp 10", bus.out_data); end
    tick();
    tb_valid = 1'b0;
    n_checks++; if (level !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_both: got level %0d ovf %b exp 4 0", level, overflow); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[k]) begin n_fail++; $display("FAIL fpp_out_%0d: got %b/%0d exp 1/%0d", k, bus.out_valid, bus.out_data, exp_q[k]); end
      tick();
    end
    n_checks++; if (level !== 3'd0 || acc_cnt !== 16'd5) begin n_fail++; $display("FAIL fpp_end: got level %0d cnt %0d exp 0 5", level, acc_cnt); end
  endtask

  task automatic test_wrap();
    logic [15:0] got [$];
    int k;
    do_reset();
    k = 0;
    for (int c = 0; c < 60 && got.size() < 12; c++) begin
      tb_valid = (c % 4 < 2) && (k < 12);
      tb_data  = 16'(k);
      tb_ready = (c % 2 == 0);
      if (bus.out_valid && tb_ready) got.push_back(bus.out_data);
      if (tb_valid) k++;
      tick();
    end
    idle_inputs();
    n_checks++; if (got.size() != 12) begin n_fail++; $display("FAIL wrap_count: got %0d exp 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < got.size()) begin
        n_checks++; if (got[i] !== 16'(i)) begin n_fail++; $display("FAIL wrap_order_%0d: got %0d exp %0d", i, got[i], i); end
      end
    end
    n_checks++; if (acc !== 32'd66 || acc_cnt !== 16'd12) begin n_fail++; $display("FAIL wrap_acc: got %0d/%0d exp 66/12", acc, acc_cnt); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b exp 0", overflow); end
  endtask

  task automatic test_ovf_clear();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tb_valid = 1'b1; tb_data = 16'hA0 + 16'(i);
      tick();
    end
    n_checks++; if (overflow !== 1'b0 || level !== 3'd4) begin n_fail++; $display("FAIL oc_full: got ovf %b level %0d exp 0 4", overflow, level); end
    tb_data = 16'hEE; tb_clr = 1'b1;
    tick();
    tb_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1 || level !== 3'd4) begin n_fail++; $display("FAIL oc_set_wins: got ovf %b level %0d exp 1 4", overflow, level); end
    tick();
    tb_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL oc_clear: got %b exp 0", overflow); end
    tb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA0 + 16'(k)) begin n_fail++; $display("FAIL oc_out_%0d: got %b/%h exp 1/%h", k, bus.out_valid, bus.out_data, 16'hA0 + 16'(k)); end
      tick();
    end
    tick(); tick();
    n_checks++; if (level !== 3'd0 || bus.out_valid !== 1'b0 || acc_cnt !== 16'd4) begin n_fail++; $display("FAIL oc_underflow: got level %0d valid %b cnt %0d exp 0 0 4", level, bus.out_valid, acc_cnt); end
    n_checks++; if (acc !== 32'h286) begin n_fail++; $display("FAIL oc_acc: got %h exp 00000286", acc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 5; i <= 8; i++) begin
      tb_valid = 1'b1; tb_data = 16'(i);
      tick();
    end
    tb_valid = 1'b0; tb_ready = 1'b1;
    tick();
    tb_ready = 1'b0;
    n_checks++; if (level !== 3'd3 || acc !== 32'd5 || acc_cnt !== 16'd1) begin n_fail++; $display("FAIL rm_pre: got level %0d acc %0d cnt %0d exp 3 5 1", level, acc, acc_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL rm_async_q: got valid %b level %0d exp 0 0", bus.out_valid, level); end
    n_checks++; if (acc !== 32'd0 || acc_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_async_acc: got %0d/%0d exp 0/0", acc, acc_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    tb_valid = 1'b1; tb_data = 16'h0077;
    tick();
    tb_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0077 || level !== 3'd1) begin n_fail++; $display("FAIL rm_first_push: got %b/%h level %0d exp 1/0077 1", bus.out_valid, bus.out_data, level); end
  endtask

  task automatic test_acc_wrap();
    do_reset();
    tb_valid = 1'b1; tb_data = 16'hFFFF;
    tick();
    tb_data = 16'h0002;
    tick();
    tb_valid = 1'b0; tb_ready = 1'b1;
    tick();
    n_checks++; if (acc16 !== 16'hFFFF) begin n_fail++; $display("FAIL aw_first: got %h exp ffff", acc16); end
    tick();
    n_checks++; if (acc16 !== 16'h0001 || acc_cnt16 !== 16'd2) begin n_fail++; $display("FAIL aw_wrap: got %h/%0d exp 0001/2", acc16, acc_cnt16); end
    n_checks++; if (acc !== 32'h0001_0001) begin n_fail++; $display("FAIL aw_wide: got %h exp 00010001", acc); end
  endtask

  task automatic test_adder_e2e();
    logic [15:0] av [10];
    logic [15:0] bv [10];
    logic [15:0] ev [10];
    logic [15:0] got [$];
    av = '{16'd1, 16'd2, 16'h0100, 16'hFFFF, 16'h1234, 16'h8000, 16'd7, 16'd0, 16'hAAAA, 16'h0F0F};
    bv = '{16'd2, 16'd3, 16'h0200, 16'h0001, 16'h4321, 16'h8000, 16'd9, 16'd0, 16'h5555, 16'hF0F0};
    ev = '{16'd3, 16'd5, 16'h0300, 16'h0000, 16'h5555, 16'h0000, 16'd16, 16'd0, 16'hFFFF, 16'hFFFF};
    do_reset();
    use_adder = 1'b1; tb_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      add_start = (c % 4 == 0) && (c / 4 < 10);
      if (add_start) begin add_a = av[c / 4]; add_b = bv[c / 4]; end
      if (bus.out_valid) got.push_back(bus.out_data);
      tick();
    end
    idle_inputs();
    n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL e2e_count: got %0d exp 10", got.size()); end
    for (int i = 0; i < 10; i++) begin
      if (i < got.size()) begin
        n_checks++; if (got[i] !== ev[i]) begin n_fail++; $display("FAIL e2e_sum_%0d: got %h exp %h", i, got[i], ev[i]); end
      end
    end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL e2e_ovf: got %b exp 0", overflow); end
    n_checks++; if (acc !== 32'h0002_586B || acc_cnt !== 16'd10) begin n_fail++; $display("FAIL e2e_acc: got %h/%0d exp 0002586b/10", acc, acc_cnt); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_drop();
    test_full_push_pop();
    test_wrap();
    test_ovf_clear();
    test_reset_mid();
    test_acc_wrap();
    test_adder_e2e();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout exp finish before 50000ns");
    $fatal(1);
  end
endmodule

// File: doc/sum_result_buffer.md
Name: sum_result_buffer

Overview:
Downstream stage of the registered adder (start/a/b -> y/valid, one-cycle latency). The adder has no backpressure, so this block captures each valid sum into a small FIFO and presents it on a ready/valid stream to the consumer. It flags results dropped on a full FIFO with a sticky bit. It also keeps a wrapping accumulator and a saturating count of all sums delivered downstream.

Parameters:
W, 16, data width; must match the adder's W.
DEPTH, 4, FIFO entries; power of two, >= 2.
ACC_W, 32, accumulator width; must be >= W.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  adder valid; one-cycle pulse per result; cannot be stalled.
in_data  in  W  adder y; sampled only when in_valid=1.
out_valid  out  1  FIFO non-empty.
out_data  out  W  head entry; meaningful only when out_valid=1.
out_ready  in  1  consumer accepts head this cycle.
level  out  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH.
overflow  out  1  sticky; set when an input result was dropped.
clr_ovf  in  1  synchronous clear of overflow.
acc  out  ACC_W  sum of all popped out_data values, modulo 2^ACC_W.
acc_cnt  out  16  number of pops, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0; level=0; out_valid=0; overflow=0; acc=0; acc_cnt=0. Storage contents are don't-care. out_data is don't-care while out_valid=0.
- Reset mid-operation discards all stored entries immediately. First push after reset release lands in entry 0.
- pop = out_valid & out_ready.
- push = in_valid & (level<DEPTH | pop).
- Push at edge N: entry written at wr_ptr; wr_ptr advances. Entry is visible at the head after edge N if the FIFO was empty. No same-cycle bypass: in_valid with an empty FIFO gives out_valid=1 only from the following cycle.
- Head is first-word fall-through. out_data = mem[rd_ptr], driven from registered storage, with no combinational path from in_data.
- Pop at edge N: rd_ptr advances; the next entry, if any, appears after edge N.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by level or by an extra pointer bit, never by pointer equality alone.
- Level update per edge:
  - push only: level +1
  - pop only: level -1
  - push and pop: level unchanged
- Full and in_valid=1 with a simultaneous pop: both operations occur, no drop, overflow unchanged.
- Full and in_valid=1 without a pop: the input is dropped and storage is unchanged. overflow is set at that edge.
- overflow stays 1 until clr_ovf=1 at an edge. If a drop and clr_ovf coincide, set wins and overflow stays 1.
- out_ready while empty has no effect; level never underflows.
- acc: on each pop, acc <= acc + zero-extended out_data, wrapping modulo 2^ACC_W.
- acc_cnt: on each pop, acc_cnt <= acc_cnt + 1, holding at 16'hFFFF.
- acc and acc_cnt are cleared only by reset.
- Outputs level, overflow, acc and acc_cnt are registered. out_valid is derived from registered state only.

Test Plan:
- Single pass-through, DEPTH=4. in_valid pulse with in_data=16'h0123, out_ready=1 -> out_valid=1 for exactly the next cycle with out_data=16'h0123; then level=0, acc=32'h123, acc_cnt=1.
- Fill and drop, out_ready=0. Push 1,2,3,4,5 on consecutive cycles -> level=4 and overflow=1 after the 5th. Then out_ready=1 -> outputs 1,2,3,4 in order, acc=10, acc_cnt=4.
- Full with simultaneous push and pop. Fill with 10,20,30,40; hold out_ready=1; push 50 in the same cycle as the pop of 10 -> level stays 4, overflow=0, drained order 20,30,40,50.
- Wrap-around. Drive 12 back-to-back results 0..11 with out_ready toggling 1,0,1,0 -> no drop, output order 0..11, acc=66, pointers cross index 0 at least twice.
- Overflow and clear interaction.
  - Pulse clr_ovf in the same cycle as a drop -> overflow stays 1.
  - Pulse clr_ovf alone next cycle -> overflow=0.
- Reset mid-stream and accumulator wrap.
  - Assert rst_n=0 with level=3 -> out_valid, level, acc and acc_cnt read 0 immediately, before the next clock edge.
  - With ACC_W=W=16, pop 16'hFFFF then 16'h0002 -> acc=16'h0001.
- End-to-end with the adder. Drive 10 adder start transactions spaced 4 cycles apart with out_ready=1 -> every popped value equals the adder's a+b, in order; overflow=0.
